wb_arbiter: RTL and testbench

Writeback arbiter that owns the single register-file write port (we3/wa3/wd3). It merges results from the main pipeline and from the multicycle unit (mul/div), which delivers results through a valid/ready handshake. A DEPTH-entry queue buffers multicycle results, and a 32-bit pending scoreboard tells decode which destinations still await a multicycle result. It sits between the writeback stage / multicycle unit and the register file, which samples we3/wa3/wd3 on the falling clock edge.

---
 rtl/wb_arbiter.sv | 99 +++++++++
 tb/tb_wb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register-file write port, merging pipeline writebacks with queued multicycle results
module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_wa,
    input  logic [31:0] mc_wd,
    input  logic        mc_issue,
    input  logic [4:0]  mc_issue_wa,
    input  logic [4:0]  chk_ra1,
    input  logic [4:0]  chk_ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall_pipe,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [36:0]   mem_q [DEPTH];
    logic [36:0]   mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          stall_q, stall_d;
    logic          we3_q, we3_d;
    logic [4:0]    wa3_q, wa3_d;
    logic [31:0]   wd3_q, wd3_d;
    logic          push, pop, pipe_wr;
    logic [4:0]    head_wa;
    logic [31:0]   head_wd;

    assign mc_ready   = cnt_q != CW'(DEPTH);
    assign pipe_wr    = pipe_we && pipe_wa != 5'd0;
    assign push       = mc_valid && mc_ready;
    assign pop        = !pipe_wr && cnt_q != '0;
    assign {head_wa, head_wd} = mem_q[rptr_q];
    assign busy1      = pending_q[chk_ra1];
    assign busy2      = pending_q[chk_ra2];
    assign stall_pipe = stall_q;
    assign we3        = we3_q;
    assign wa3        = wa3_q;
    assign wd3        = wd3_q;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = {mc_wa, mc_wd};
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        // r0 entries are popped but never emitted
        we3_d = pipe_wr || (pop && head_wa != 5'd0);
        wa3_d = pipe_wr ? pipe_wa : (we3_d ? head_wa : 5'd0);
        wd3_d = pipe_wr ? pipe_wd : (we3_d ? head_wd : 32'd0);
        pending_d = pending_q;
        if (pop && head_wa != 5'd0) pending_d[head_wa] = 1'b0;
        if (mc_issue) pending_d[mc_issue_wa] = 1'b1;
        pending_d[0] = 1'b0;
        starve_d = (pipe_wr && cnt_q != '0) ? starve_q + 1'b1 : '0;
        stall_d = starve_d == SW'(STARVE_MAX);
        if (stall_d) starve_d = '0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            pending_q <= '0;
            stall_q   <= 1'b0;
            we3_q     <= 1'b0;
            wa3_q     <= 5'd0;
            wd3_q     <= 32'd0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of wb_arbiter with a falling-edge register-file model
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_wa;
    logic [31:0] mc_wd;
    logic        mc_issue;
    logic [4:0]  mc_issue_wa;
    logic [4:0]  chk_ra1, chk_ra2;
    logic        busy1, busy2;
    logic        stall_pipe;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] rf [32];
    int          r0_writes = 0;
    int          checks = 0;
    int          errors = 0;

    wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wa(mc_wa), .mc_wd(mc_wd),
        .mc_issue(mc_issue), .mc_issue_wa(mc_issue_wa),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .busy1(busy1), .busy2(busy2),
        .stall_pipe(stall_pipe), .we3(we3), .wa3(wa3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we3) rf[wa3] <= wd3;
        if (we3 && wa3 == 5'd0) r0_writes <= r0_writes + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
        mc_valid = 0; mc_wa = 0; mc_wd = 0; mc_issue = 0; mc_issue_wa = 0;
        chk_ra1 = 5; chk_ra2 = 9;
        tick(); tick();
        rst = 0;
        chk("rst_we3", 32'(we3), 0);
        chk("rst_wa3", 32'(wa3), 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_stall", 32'(stall_pipe), 0);
        chk("rst_ready", 32'(mc_ready), 1);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_busy2", 32'(busy2), 0);

        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'hDEADBEEF;
        tick();
        pipe_we = 0;
        chk("pipe_we3", 32'(we3), 1);
        chk("pipe_wa3", 32'(wa3), 5);
        chk("pipe_wd3", wd3, 32'hDEADBEEF);
        tick();
        chk("pipe_pulse_end", 32'(we3), 0);
        chk("pipe_idle_wa3", 32'(wa3), 0);
        chk("rf_r5", rf[5], 32'hDEADBEEF);

        mc_valid = 1; mc_wa = 7; mc_wd = 32'h77; pipe_we = 1; pipe_wa = 3; pipe_wd = 32'h33;
        tick();
        chk("preempt_wa3", 32'(wa3), 3);
        mc_valid = 0; pipe_we = 1; pipe_wa = 0; pipe_wd = 32'h1234;
        tick();
        pipe_we = 0;
        chk("r0pipe_we3", 32'(we3), 1);
        chk("r0pipe_wa3", 32'(wa3), 7);
        chk("r0pipe_wd3", wd3, 32'h77);
        tick();
        chk("r0pipe_idle", 32'(we3), 0);
        chk("rf_r7", rf[7], 32'h77);
        chk("r0_writes", 32'(r0_writes), 0);

        mc_issue = 1; mc_issue_wa = 9; chk_ra1 = 9;
        tick();
        mc_issue = 0;
        chk("issue_busy1", 32'(busy1), 1);
        chk("issue_busy2", 32'(busy2), 1);
        mc_valid = 1; mc_wa = 9; mc_wd = 32'h99;
        tick();
        mc_valid = 0;
        chk("r9_push_busy", 32'(busy1), 1);
        chk("r9_push_we3", 32'(we3), 0);
        tick();
        chk("r9_we3", 32'(we3), 1);
        chk("r9_wa3", 32'(wa3), 9);
        tick();
        chk("r9_after_we3", 32'(we3), 0);
        chk("r9_after_busy", 32'(busy1), 0);

        pipe_we = 1; pipe_wa = 1; pipe_wd = 32'h1;
        mc_valid = 1; mc_wa = 10; mc_wd = 32'hA0;
        tick();
        chk("st1_ready", 32'(mc_ready), 1);
        mc_wa = 11; mc_wd = 32'hB0; pipe_wa = 2;
        tick();
        chk("st2_ready", 32'(mc_ready), 0);
        mc_wa = 12; mc_wd = 32'hC0; pipe_wa = 3;
        tick();
        chk("st3_ready", 32'(mc_ready), 0);
        chk("st3_stall", 32'(stall_pipe), 0);
        pipe_wa = 4;
        tick();
        chk("st4_stall", 32'(stall_pipe), 0);
        chk("st4_wa3", 32'(wa3), 4);
        pipe_wa = 5;
        tick();
        chk("st5_stall", 32'(stall_pipe), 1);
        chk("st5_ready", 32'(mc_ready), 0);
        pipe_we = 0;
        tick();
        chk("drain_a_wa3", 32'(wa3), 10);
        chk("drain_a_wd3", wd3, 32'hA0);
        chk("drain_a_stall", 32'(stall_pipe), 0);
        chk("drain_a_ready", 32'(mc_ready), 1);
        tick();
        mc_valid = 0;
        chk("drain_b_wa3", 32'(wa3), 11);
        chk("drain_b_wd3", wd3, 32'hB0);
        tick();
        chk("drain_c_wa3", 32'(wa3), 12);
        chk("drain_c_wd3", wd3, 32'hC0);
        tick();
        chk("drain_idle", 32'(we3), 0);

        mc_issue = 1; mc_issue_wa = 3; chk_ra2 = 3;
        tick();
        mc_issue = 0;
        mc_valid = 1; mc_wa = 3; mc_wd = 32'h3C;
        tick();
        mc_valid = 0; mc_issue = 1; mc_issue_wa = 3;
        tick();
        mc_issue = 0;
        chk("same_edge_wa3", 32'(wa3), 3);
        chk("same_edge_busy", 32'(busy2), 1);
        tick();
        chk("same_edge_hold", 32'(busy2), 1);

        mc_valid = 1; mc_wa = 0; mc_wd = 32'h5;
        tick();
        mc_valid = 0;
        tick();
        chk("r0_pop_we3", 32'(we3), 0);
        chk("r0_pop_ready", 32'(mc_ready), 1);

        mc_issue = 1; mc_issue_wa = 20; chk_ra1 = 20;
        pipe_we = 1; pipe_wa = 4; pipe_wd = 32'h44;
        mc_valid = 1; mc_wa = 20; mc_wd = 32'h20;
        tick();
        mc_issue = 0; mc_wa = 21; mc_wd = 32'h21;
        tick();
        chk("pre_rst_ready", 32'(mc_ready), 0);
        chk("pre_rst_busy1", 32'(busy1), 1);
        rst = 1; pipe_we = 0; mc_valid = 0;
        tick();
        rst = 0;
        chk("post_rst_we3", 32'(we3), 0);
        chk("post_rst_ready", 32'(mc_ready), 1);
        chk("post_rst_busy1", 32'(busy1), 0);
        chk("post_rst_busy2", 32'(busy2), 0);
        tick();
        chk("post_rst_we3_1", 32'(we3), 0);
        tick();
        chk("post_rst_we3_2", 32'(we3), 0);
        chk("post_rst_stall", 32'(stall_pipe), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
